dispatch_buffer: RTL
====================

DISPATCH_BUFFER -- requirements
Module: dispatch_buffer

Interface
REQ-001 Parameter INST_ID_BITS, default 6, instruction tag width.
REQ-002 Parameter PRN_BITS, default 6, physical register number width.
REQ-003 Parameter MAX_OPERANDS, default 3, source/destination operand slots.
REQ-004 Parameter DEPTH, default 4, buffer entries; power of 2, at least 2.
REQ-005 Parameter FU_COUNT, default 4, wakeup broadcast ports.
REQ-006 Parameter NUM_IQ, fixed at 3, issue queues: 0=ALU, 1=LSU, 2=BRANCH.
REQ-007 clk  in  1  sole clock; all state updates on posedge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 flush  in  1  synchronous squash of all buffered entries.
REQ-010 in_valid / in_ready  in/out  1  renamer handshake.
REQ-011 inst_id, raw_instr[32], instr_pc[64]  in  incoming instruction payload.
REQ-012 prn_input_valid, prn_input_ready  in  MAX_OPERANDS x 1  source operand used / source operand ready.
REQ-013 prn_input  in  MAX_OPERANDS x PRN_BITS  source PRNs.
REQ-014 prn_output_valid, prn_output  in  MAX_OPERANDS x (1, PRN_BITS)  destination PRNs.
REQ-015 set_prn_ready, set_prn  in  FU_COUNT x MAX_OPERANDS x (1, PRN_BITS)  wakeup broadcast.
REQ-016 iq_inst_valid  out  NUM_IQ x 1  per-queue valid; at most one bit set per cycle.
REQ-017 iq_queue_ready  in  NUM_IQ x 1  per-queue accept.
REQ-018 Outputs iq_inst_id, iq_raw_instr, iq_instr_pc, iq_prn_input_valid, iq_prn_input_ready, iq_prn_input, iq_prn_output_valid, iq_prn_output  out  shared head payload; widths match the corresponding inputs.
REQ-019 count  out  clog2(DEPTH)+1  occupancy.

Function
REQ-020 Circular FIFO with head and tail pointers; one enqueue and one dequeue per cycle; pointers wrap modulo DEPTH.
REQ-021 in_ready = (count < DEPTH) and not flush; it does not depend on the same-cycle dequeue.
REQ-022 Enqueue occurs when in_valid and in_ready; the entry is visible at the head no earlier than the next cycle, unless bypass applies (see Configuration).
REQ-023 Steering classifies raw_instr[28:25]: x1x0 -> LSU; 101x -> BRANCH; everything else, including data-processing and undefined encodings, -> ALU.
REQ-024 iq_inst_valid[k] = not empty and head class == k; dispatch is in order only, and a not-ready target blocks the head.
REQ-025 Dequeue occurs when iq_inst_valid[k] and iq_queue_ready[k]; the payload is held stable while it is stalled.
REQ-026 Wakeup: a buffered entry sets op_ready[j] when its op_valid[j] is set and any set_prn_ready[f][j] matches op_prn[j] with set_prn[f][j].
REQ-027 The wakeup of REQ-026 also ORs combinationally into iq_prn_input_ready on the head, so a transfer cycle loses no wakeups.
REQ-028 The wakeup of REQ-026 also applies to an entry enqueued in the same cycle.
REQ-029 Simultaneous enqueue and dequeue: count is unchanged and both pointers advance; this is legal when full only if in_ready was already high.
REQ-030 flush empties the buffer: count=0, head=tail, iq_inst_valid all 0 next cycle; flush overrides a same-cycle enqueue.
REQ-031 When empty, iq_inst_valid=0 and the payload outputs are don't-care, but they must not be X from uninitialised state.

Reset
REQ-032 On rst_n low, asynchronously: head=tail=0, count=0, all entry valid/ready bits 0.
REQ-033 During reset, iq_inst_valid=0 and in_ready=0.
REQ-034 in_ready rises the first cycle after rst_n deasserts.
REQ-035 Reset asserted mid-transfer discards all entries with no partial dispatch.

Configuration
REQ-036 Macro DISPATCH_BYPASS_EN: when defined, with the buffer empty and the incoming class's iq_queue_ready high, the input drives the outputs combinationally and transfers in the same cycle without being written.
REQ-037 With DISPATCH_BYPASS_EN undefined, the minimum in-to-out latency is 1 cycle.

Structure
REQ-038 Package dispatch_pkg holds the class enum (IQ_ALU, IQ_LSU, IQ_BRANCH), NUM_IQ, and the buffered-entry struct typedef.
REQ-039 Sub-module inst_classifier is a combinational raw_instr -> class decoder, reused by the bypass path and the enqueue path.

Verification
REQ-040 Enqueue ADD (raw_instr[28:25]=4'b1000), iq_queue_ready=3'b111 -> iq_inst_valid=3'b001 one cycle later, count 1 then 0.
REQ-041 Fill 4 entries with iq_queue_ready=0 -> count=4, in_ready=0; then raise ready for the head class -> one dequeue per cycle, in_ready=1 after the first.
REQ-042 Head LDR (LSU) with LSU not ready, next entry ALU -> ALU entry not dispatched (in-order blocking) until the LSU transfer completes.
REQ-043 Buffered entry op_prn[1]=5 not ready, broadcast set_prn[2][1]=5 with ready -> iq_prn_input_ready[1]=1 in the same cycle and thereafter.
REQ-044 Full buffer with flush and in_valid together -> count=0, iq_inst_valid=0 next cycle, input not accepted.
REQ-045 With DISPATCH_BYPASS_EN, empty buffer and ALU ready -> iq_inst_valid[0]=1 in the enqueue cycle and count stays 0.

Source files
------------

// File: rtl/dispatch_buffer_pkg.sv
// Shared types for the dispatch buffer: issue-queue classes and the fixed-width buffered payload.
package dispatch_pkg;

    localparam int NUM_IQ = 3;

    typedef enum logic [1:0] {
        IQ_ALU    = 2'd0,
        IQ_LSU    = 2'd1,
        IQ_BRANCH = 2'd2
    } iq_class_e;

    // Parameter-width fields (tags, PRNs) live in parallel arrays in the top module.
    typedef struct packed {
        logic [31:0] raw_instr;
        logic [63:0] instr_pc;
        iq_class_e   iq_class;
    } dispatch_entry_t;

    function automatic logic [NUM_IQ-1:0] class_onehot(input iq_class_e c);
        case (c)
            IQ_LSU:    return 3'b010;
            IQ_BRANCH: return 3'b100;
            default:   return 3'b001;
        endcase
    endfunction

endpackage

// File: rtl/dispatch_buffer_inst_classifier.sv
// Combinational steering decoder: raw_instr[28:25] selects the target issue queue.
module inst_classifier
    import dispatch_pkg::*;
(
    input  logic [3:0] op_field,
    output iq_class_e  iq_class
);

    always_comb begin
        iq_class = IQ_ALU;
        casez (op_field)
            4'b?1?0: iq_class = IQ_LSU;
            4'b101?: iq_class = IQ_BRANCH;
            default: iq_class = IQ_ALU;
        endcase
    end

endmodule

// File: rtl/dispatch_buffer.sv
// In-order dispatch FIFO between rename and the ALU/LSU/BRANCH issue queues, with operand wakeup.
// Optional same-cycle empty-buffer bypass is enabled by defining DISPATCH_BYPASS_EN.
module dispatch_buffer
    import dispatch_pkg::*;
#(
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3,
    parameter int DEPTH        = 4,
    parameter int FU_COUNT     = 4
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         flush,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [INST_ID_BITS-1:0]                      inst_id,
    input  logic [31:0]                                  raw_instr,
    input  logic [63:0]                                  instr_pc,
    input  logic [MAX_OPERANDS-1:0]                      prn_input_valid,
    input  logic [MAX_OPERANDS-1:0]                      prn_input_ready,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]        prn_input,
    input  logic [MAX_OPERANDS-1:0]                      prn_output_valid,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]        prn_output,
    input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]        set_prn_ready,
    input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] set_prn,
    output logic [NUM_IQ-1:0]                            iq_inst_valid,
    input  logic [NUM_IQ-1:0]                            iq_queue_ready,
    output logic [INST_ID_BITS-1:0]                      iq_inst_id,
    output logic [31:0]                                  iq_raw_instr,
    output logic [63:0]                                  iq_instr_pc,
    output logic [MAX_OPERANDS-1:0]                      iq_prn_input_valid,
    output logic [MAX_OPERANDS-1:0]                      iq_prn_input_ready,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]        iq_prn_input,
    output logic [MAX_OPERANDS-1:0]                      iq_prn_output_valid,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]        iq_prn_output,
    output logic [$clog2(DEPTH):0]                       count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    dispatch_entry_t                       entry_q     [DEPTH];
    logic [INST_ID_BITS-1:0]               id_q        [DEPTH];
    logic [MAX_OPERANDS-1:0]               op_valid_q  [DEPTH];
    logic [MAX_OPERANDS-1:0]               op_ready_q  [DEPTH];
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] op_prn_q    [DEPTH];
    logic [MAX_OPERANDS-1:0]               dst_valid_q [DEPTH];
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] dst_prn_q   [DEPTH];
    logic [MAX_OPERANDS-1:0]               wake_hit    [DEPTH];

    logic [PW-1:0]           head_q, tail_q;
    logic [CW-1:0]           count_q;
    logic                    active_q;
    logic                    empty, bypass, enq, deq;
    logic [NUM_IQ-1:0]       head_oh;
    logic [MAX_OPERANDS-1:0] in_wake;
    iq_class_e               in_class;

    function automatic logic [MAX_OPERANDS-1:0] wake(input logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] prn);
        logic [MAX_OPERANDS-1:0] hit;
        hit = '0;
        for (int j = 0; j < MAX_OPERANDS; j++)
            for (int f = 0; f < FU_COUNT; f++)
                if (set_prn_ready[f][j] && (set_prn[f][j] == prn[j])) hit[j] = 1'b1;
        return hit;
    endfunction

    inst_classifier u_classifier (
        .op_field (raw_instr[28:25]),
        .iq_class (in_class)
    );

    assign in_wake = prn_input_valid & wake(prn_input);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) wake_hit[i] = op_valid_q[i] & wake(op_prn_q[i]);
    end

    assign empty    = (count_q == '0);
    // active_q keeps in_ready low through reset and rises on the first edge after release
    assign in_ready = active_q && (count_q < DEPTH_C) && !flush;

`ifdef DISPATCH_BYPASS_EN
    assign bypass = empty && in_valid && in_ready && |(class_onehot(in_class) & iq_queue_ready);
`else
    assign bypass = 1'b0;
`endif

    assign enq           = in_valid && in_ready && !bypass;
    assign head_oh       = empty ? '0 : class_onehot(entry_q[head_q].iq_class);
    assign deq           = |(head_oh & iq_queue_ready);
    assign iq_inst_valid = bypass ? class_onehot(in_class) : head_oh;
    assign count         = count_q;

    always_comb begin
        if (bypass) begin
            iq_inst_id          = inst_id;
            iq_raw_instr        = raw_instr;
            iq_instr_pc         = instr_pc;
            iq_prn_input_valid  = prn_input_valid;
            iq_prn_input_ready  = prn_input_ready | in_wake;
            iq_prn_input        = prn_input;
            iq_prn_output_valid = prn_output_valid;
            iq_prn_output       = prn_output;
        end else begin
            iq_inst_id          = id_q[head_q];
            iq_raw_instr        = entry_q[head_q].raw_instr;
            iq_instr_pc         = entry_q[head_q].instr_pc;
            iq_prn_input_valid  = op_valid_q[head_q];
            iq_prn_input_ready  = op_ready_q[head_q] | wake_hit[head_q];
            iq_prn_input        = op_prn_q[head_q];
            iq_prn_output_valid = dst_valid_q[head_q];
            iq_prn_output       = dst_prn_q[head_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i]     <= '0;
                id_q[i]        <= '0;
                op_valid_q[i]  <= '0;
                op_ready_q[i]  <= '0;
                op_prn_q[i]    <= '0;
                dst_valid_q[i] <= '0;
                dst_prn_q[i]   <= '0;
            end
        end else begin
            active_q <= 1'b1;
            for (int i = 0; i < DEPTH; i++) op_ready_q[i] <= op_ready_q[i] | wake_hit[i];
            if (flush) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (enq) begin
                    entry_q[tail_q]     <= '{raw_instr: raw_instr, instr_pc: instr_pc, iq_class: in_class};
                    id_q[tail_q]        <= inst_id;
                    op_valid_q[tail_q]  <= prn_input_valid;
                    op_ready_q[tail_q]  <= prn_input_ready | in_wake;
                    op_prn_q[tail_q]    <= prn_input;
                    dst_valid_q[tail_q] <= prn_output_valid;
                    dst_prn_q[tail_q]   <= prn_output;
                    tail_q              <= tail_q + 1'b1;
                end
                if (deq) head_q <= head_q + 1'b1;
                case ({enq, deq})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

endmodule
